dff_pipe: RTL and testbench

Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit data flip-flops, each with its own valid bit and a valid/ready handshake at both ends.
Generalises the single-bit D flip-flop with reset to:
- configurable width and depth
- per-stage stall with bubble collapsing
- synchronous flush
- live occupancy count
Used as the standard retiming and delay element between datapath blocks.

---
 rtl/dff_pipe_pkg.sv | 12 +
 rtl/dff_pipe_stage.sv | 31 +++
 rtl/dff_pipe.sv | 81 ++++++++
 tb/tb_dff_pipe.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_pipe_pkg.sv
// Shared defaults and sizing helpers for the dff_pipe elastic register pipeline.
package dff_pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 4;

  // Bits needed to count 0..depth valid stages.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: valid bit plus data register, advancing when adv is high.
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int unsigned          WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             flush,
  input  logic             adv,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  always_ff @(posedge clk) begin
    if (!rst_l || flush) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else if (adv) begin
      v <= up_valid;
      // Data only toggles when a real word moves in; bubbles leave it untouched.
      if (up_valid) begin
        d <= up_data;
      end
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Elastic DEPTH-stage register pipeline with bubble collapsing, flush and occupancy.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned      DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic             in_xfer;
  logic             out_xfer;

  // Ready ripples back combinationally so a stage may load whenever anything
  // downstream of it moves or it is empty (bubble collapsing).
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = out_ready | ~v[DEPTH-1];
    for (int unsigned k = 1; k < DEPTH; k++) begin
      adv[DEPTH-1-k] = adv[DEPTH-k] | ~v[DEPTH-1-k];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      dff_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk     (clk),
        .rst_l   (rst_l),
        .flush   (flush),
        .adv     (adv[i]),
        .up_valid(in_valid),
        .up_data (in_data),
        .v       (v[i]),
        .d       (d[i])
      );
    end else begin : g_next
      dff_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk     (clk),
        .rst_l   (rst_l),
        .flush   (flush),
        .adv     (adv[i]),
        .up_valid(v[i-1]),
        .up_data (d[i-1]),
        .v       (v[i]),
        .d       (d[i])
      );
    end
  end

  assign in_ready  = adv[0] & rst_l & ~flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_l || flush) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (!in_xfer && out_xfer) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe: directed DEPTH=4 cases plus random DEPTH=1/7 traffic.
module tb_dff_pipe;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic flush = 1'b0;

  logic       iv4 = 1'b0, ir4, ov4, or4 = 1'b1;
  logic [7:0] id4 = '0, od4;
  logic [2:0] occ4;
  logic       iv1 = 1'b0, ir1, ov1, or1 = 1'b1;
  logic [7:0] id1 = '0, od1;
  logic [0:0] occ1;
  logic       iv7 = 1'b0, ir7, ov7, or7 = 1'b1;
  logic [7:0] id7 = '0, od7;
  logic [2:0] occ7;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int peak = 0;
  bit mon_en = 1'b0;
  int q [3][$];
  int cnt [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_d4 (
    .clk(clk), .rst_l(rst_l), .flush(flush), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .occupancy(occ4));
  dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_d1 (
    .clk(clk), .rst_l(rst_l), .flush(flush), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(occ1));
  dff_pipe #(.WIDTH(8), .DEPTH(7), .RESET_VAL(8'h00)) u_d7 (
    .clk(clk), .rst_l(rst_l), .flush(flush), .in_valid(iv7), .in_ready(ir7), .in_data(id7),
    .out_valid(ov7), .out_ready(or7), .out_data(od7), .occupancy(occ7));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compare each output transfer against the expected queue, and the
  // occupancy / in_ready against the model count.
  task automatic mon(input int id, input int depth, input int iv, input int ir, input int idat,
                     input int ov, input int orr, input int od, input int occ);
    int e;
    check($sformatf("occupancy[%0d]", id), occ, cnt[id]);
    check($sformatf("in_ready[%0d]", id), ir,
          (rst_l && !flush && (cnt[id] < depth || orr != 0)) ? 1 : 0);
    if (cnt[id] == 0) check($sformatf("out_valid_empty[%0d]", id), ov, 0);
    if (ov != 0 && orr != 0) begin
      if (q[id].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_unexpected[%0d]: got 0x%0h required no output", id, od);
      end else begin
        e = q[id].pop_front();
        check($sformatf("out_data[%0d]", id), od, e);
      end
    end
    if (!rst_l || flush) begin
      q[id].delete();
      cnt[id] = 0;
    end else begin
      if (iv != 0 && ir != 0) begin
        q[id].push_back(idat);
        cnt[id]++;
      end
      if (ov != 0 && orr != 0) cnt[id]--;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(occ4) > peak) peak = int'(occ4);
      mon(0, 4, iv4, ir4, id4, ov4, or4, od4, occ4);
      mon(1, 1, iv1, ir1, id1, ov1, or1, od1, occ1);
      mon(2, 7, iv7, ir7, id7, ov7, or7, od7, occ7);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [7:0] w, output int acc);
    bit got;
    int n;
    got = 0;
    n = 0;
    acc = 0;
    iv4 = 1'b1;
    id4 = w;
    while (!got && n < 20) begin
      @(negedge clk);
      got = ir4;
      acc = cyc;
      tick();
      n++;
    end
    check($sformatf("send_accept_%0h", w), got, 1);
  endtask

  task automatic wait_out4(output int at, output logic [7:0] dat);
    bit got;
    int n;
    got = 0;
    n = 0;
    at = 0;
    dat = '0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (ov4) begin
        got = 1;
        at = cyc;
        dat = od4;
      end
      tick();
      n++;
    end
    check("wait_out_valid", got, 1);
  endtask

  task automatic drain4;
    int n;
    iv4 = 1'b0;
    or4 = 1'b1;
    n = 0;
    while (occ4 != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain_empty", occ4, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int c, t, a;
    logic [7:0] dat;

    // Reset state; in_ready forced low while rst_l=0
    tick();
    tick();
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_occupancy", occ4, 0);
    check("rst_out_valid", ov4, 0);
    check("rst_out_data", od4, 8'h00);
    check("rst_in_ready", ir4, 0);
    tick();
    rst_l = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", ir4, 1);
    tick();

    // 1: latency and back-to-back flow
    peak = 0;
    or4 = 1'b1;
    send4(8'h11, c);
    send4(8'h22, a);
    send4(8'h33, a);
    iv4 = 1'b0;
    wait_out4(t, dat);
    check("latency", t - c, 4);
    check("first_out", dat, 8'h11);
    @(negedge clk);
    check("second_valid", ov4, 1);
    check("second_out", od4, 8'h22);
    tick();
    @(negedge clk);
    check("third_valid", ov4, 1);
    check("third_out", od4, 8'h33);
    tick();
    drain4();
    check("peak_occupancy", peak, 3);

    // 2: stalled output, only DEPTH words accepted, then gap-free drain
    or4 = 1'b0;
    for (int i = 0; i < 4; i++) send4(8'hA0 + 8'(i), a);
    id4 = 8'hA4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", ir4, 0);
      check("full_occupancy", occ4, 4);
      check("full_out_data", od4, 8'hA0);
      tick();
    end
    or4 = 1'b1;
    @(negedge clk);
    check("flow_valid_0", ov4, 1);
    check("flow_in_ready_0", ir4, 1);
    tick();
    id4 = 8'hA5;
    @(negedge clk);
    check("flow_valid_1", ov4, 1);
    check("flow_in_ready_1", ir4, 1);
    tick();
    iv4 = 1'b0;
    for (int i = 2; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("flow_valid_%0d", i), ov4, 1);
      tick();
    end
    drain4();

    // 3: full pipeline with simultaneous in and out transfer
    or4 = 1'b0;
    for (int i = 0; i < 4; i++) send4(8'hB0 + 8'(i), a);
    iv4 = 1'b0;
    @(negedge clk);
    check("b_full_occupancy", occ4, 4);
    check("b_full_in_ready", ir4, 0);
    tick();
    or4 = 1'b1;
    iv4 = 1'b1;
    id4 = 8'hB4;
    @(negedge clk);
    check("passthru_in_ready", ir4, 1);
    check("passthru_out_valid", ov4, 1);
    check("passthru_out_data", od4, 8'hB0);
    tick();
    iv4 = 1'b0;
    or4 = 1'b0;
    @(negedge clk);
    check("passthru_occupancy", occ4, 4);
    tick();
    drain4();

    // 4: flush drops the same-cycle input
    or4 = 1'b0;
    for (int i = 0; i < 3; i++) send4(8'hC0 + 8'(i), a);
    flush = 1'b1;
    iv4 = 1'b1;
    id4 = 8'h55;
    @(negedge clk);
    check("flush_in_ready", ir4, 0);
    tick();
    flush = 1'b0;
    iv4 = 1'b0;
    @(negedge clk);
    check("flush_occupancy", occ4, 0);
    check("flush_out_valid", ov4, 0);
    check("flush_out_data", od4, 8'h00);
    tick();
    or4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_no_output", ov4, 0);
      tick();
    end

    // 5: synchronous reset mid-stream
    or4 = 1'b0;
    send4(8'hD0, a);
    send4(8'hD1, a);
    rst_l = 1'b0;
    id4 = 8'h77;
    @(negedge clk);
    check("rst_not_before_edge", occ4, 2);
    check("rst_in_ready_low", ir4, 0);
    tick();
    rst_l = 1'b1;
    iv4 = 1'b0;
    @(negedge clk);
    check("rst_cleared_occupancy", occ4, 0);
    check("rst_cleared_valid", ov4, 0);
    tick();
    or4 = 1'b1;
    send4(8'hD5, c);
    iv4 = 1'b0;
    wait_out4(t, dat);
    check("post_rst_latency", t - c, 4);
    check("post_rst_data", dat, 8'hD5);

    // 6: random traffic on DEPTH=1 and DEPTH=7
    for (int i = 0; i < 1000; i++) begin
      iv1 = 1'($urandom_range(0, 1));
      id1 = 8'($urandom);
      or1 = 1'($urandom_range(0, 1));
      iv7 = 1'($urandom_range(0, 1));
      id7 = 8'($urandom);
      or7 = 1'($urandom_range(0, 1));
      tick();
    end
    iv1 = 1'b0;
    iv7 = 1'b0;
    or1 = 1'b1;
    or7 = 1'b1;
    repeat (12) tick();
    check("d1_drained", q[1].size(), 0);
    check("d7_drained", q[2].size(), 0);
    check("d4_drained", q[0].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
